// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear controller for a six-digit mm:ss.cc stopwatch.
// A prescaled tick advances a BCD time count while running. The time (or the
// frozen lap value) drives six registered, active-low 7-segment outputs.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start_stop         : one-cycle pulse, toggles run/pause
//   lap_clr            : one-cycle pulse, lap while running, clear while stopped
//   numb_0..numb_5     : segments g..a for cc units .. mm tens (active-low)
//   running            : RUN or LAP
//   lap_active         : LAP (display frozen)
//   ovf                : saturated at 59:59.99
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap_clr,
  output logic [6:0] numb_0,
  output logic [6:0] numb_1,
  output logic [6:0] numb_2,
  output logic [6:0] numb_3,
  output logic [6:0] numb_4,
  output logic [6:0] numb_5,
  output logic       running,
  output logic       lap_active,
  output logic       ovf
);

  localparam int unsigned PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [23:0] CNT_MAX   = 24'h595999;
  localparam logic [6:0]  SEG_ZERO  = 7'b1000000;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_LAP   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_OVF   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [23:0]     cnt_q, cnt_d;      // {mm10, mm1, ss10, ss1, cc10, cc1}
  logic [23:0]     latch_q, latch_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [5:0][6:0] seg_q, seg_d;
  logic            running_q, running_d;
  logic            lap_q, lap_d;
  logic            ovf_q, ovf_d;

  logic            counting;
  logic            tick;
  logic            at_max;
  logic [23:0]     disp;

  // Increment packed BCD time with cc->ss->mm ripple carry.
  function automatic logic [23:0] bcd_inc(input logic [23:0] c);
    logic [23:0] r;
    r = c;
    if (c[3:0] != 4'd9) r[3:0] = c[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (c[7:4] != 4'd9) r[7:4] = c[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (c[11:8] != 4'd9) r[11:8] = c[11:8] + 4'd1;
        else begin
          r[11:8] = 4'd0;
          if (c[15:12] != 4'd5) r[15:12] = c[15:12] + 4'd1;
          else begin
            r[15:12] = 4'd0;
            if (c[19:16] != 4'd9) r[19:16] = c[19:16] + 4'd1;
            else begin
              r[19:16] = 4'd0;
              if (c[23:20] != 4'd5) r[23:20] = c[23:20] + 4'd1;
              else                  r[23:20] = 4'd0;
            end
          end
        end
      end
    end
    return r;
  endfunction

  // Active-low segment decode, bit[6:0] = g..a; non-BCD values blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Next-state: tick/increment first, then the button-driven transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_d  = latch_q;
    presc_d  = presc_q;
    counting = (state_q == S_RUN) || (state_q == S_LAP);
    tick     = counting && (presc_q == PRESC_MAX);
    at_max   = (cnt_q == CNT_MAX);

    if (counting) presc_d = tick ? '0 : PW'(presc_q + 1'b1);
    if (tick && !at_max) cnt_d = bcd_inc(cnt_q);

    case (state_q)
      S_IDLE: begin
        if (start_stop) state_d = S_RUN;
      end
      S_RUN, S_LAP: begin
        // Saturating tick wins over any coincident button.
        if (tick && at_max) state_d = S_OVF;
        else if (start_stop) state_d = S_PAUSE;
        else if (lap_clr) begin
          state_d = S_LAP;
          latch_d = cnt_q;  // pre-increment value
        end
      end
      S_PAUSE: begin
        if (start_stop) state_d = S_RUN;
        else if (lap_clr) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          presc_d = '0;
        end
      end
      S_OVF: begin
        if (lap_clr) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          presc_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        presc_d = '0;
      end
    endcase

    disp = (state_q == S_LAP) ? latch_q : cnt_q;
    for (int i = 0; i < 6; i++) seg_d[i] = seg7(disp[4*i +: 4]);

    running_d = (state_d == S_RUN) || (state_d == S_LAP);
    lap_d     = (state_d == S_LAP);
    ovf_d     = (state_d == S_OVF);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      latch_q   <= '0;
      presc_q   <= '0;
      seg_q     <= {6{SEG_ZERO}};
      running_q <= 1'b0;
      lap_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      latch_q   <= latch_d;
      presc_q   <= presc_d;
      seg_q     <= seg_d;
      running_q <= running_d;
      lap_q     <= lap_d;
      ovf_q     <= ovf_d;
    end
  end

  assign numb_0     = seg_q[0];
  assign numb_1     = seg_q[1];
  assign numb_2     = seg_q[2];
  assign numb_3     = seg_q[3];
  assign numb_4     = seg_q[4];
  assign numb_5     = seg_q[5];
  assign running    = running_q;
  assign lap_active = lap_q;
  assign ovf        = ovf_q;

endmodule
